game_round_ctrl: RTL

- Parametrised successor to the single-round Menu/Game/End controller in the game top level.
- Sequences a best-of-N match: menu, pre-round countdown, timed play with pause, round result hold, and match end with rematch.
- Tracks per-round points and per-match round wins, gates car/money spawning, and drives the LED time bar.
- Sits in the game top level, clocked by the frame clock. Players, lanes and money consume SpawnEnable and State.

---
 rtl/game_round_ctrl_if.sv | 35 +++
 rtl/game_round_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/game_round_ctrl_if.sv
// game_round_ctrl_if: key/score inputs and match status outputs of the
// round controller. The master side (key decode, scoring logic) drives the
// inputs. The slave side (the controller) drives the status.
interface game_round_ctrl_if #(
  parameter int SCORE_W = 8,
  parameter int LED_W   = 10
);
  logic               Continue;
  logic               Pause;
  logic               P1Point;
  logic               P2Point;
  logic [2:0]         State;
  logic               SpawnEnable;
  logic [7:0]         RoundNum;
  logic [SCORE_W-1:0] P1Hits;
  logic [SCORE_W-1:0] P2Hits;
  logic [7:0]         P1Wins;
  logic [7:0]         P2Wins;
  logic [1:0]         Winner;
  logic               RoundStart;
  logic               RoundEnd;
  logic [LED_W-1:0]   LED;

  modport master (
    output Continue, Pause, P1Point, P2Point,
    input  State, SpawnEnable, RoundNum, P1Hits, P2Hits, P1Wins, P2Wins,
           Winner, RoundStart, RoundEnd, LED
  );

  modport slave (
    input  Continue, Pause, P1Point, P2Point,
    output State, SpawnEnable, RoundNum, P1Hits, P2Hits, P1Wins, P2Wins,
           Winner, RoundStart, RoundEnd, LED
  );
endinterface

// File: rtl/game_round_ctrl.sv
// game_round_ctrl: best-of-NUM_ROUNDS match sequencer.
// Flow: MENU -> COUNTDOWN -> PLAY <-> PAUSED -> ROUND_END -> COUNTDOWN | MATCH_END.
// It also tracks per-round hits and per-match wins, gates spawning and
// drives the LED time bar.
// Optional: define GAME_SUDDEN_DEATH_EN to play extra rounds while the
// wins are tied after the last scheduled round.
module game_round_ctrl #(
  parameter int ROUND_FRAMES     = 7142,
  parameter int COUNTDOWN_FRAMES = 180,
  parameter int RESULT_FRAMES    = 120,
  parameter int NUM_ROUNDS       = 3,
  parameter int LED_W            = 10,
  parameter int SCORE_W          = 8
) (
  input logic              FrameClk,
  input logic              Reset,
  game_round_ctrl_if.slave bus
);
  localparam int TW   = (ROUND_FRAMES > 1) ? $clog2(ROUND_FRAMES) : 1;
  localparam int CMAX = (COUNTDOWN_FRAMES > RESULT_FRAMES) ? COUNTDOWN_FRAMES : RESULT_FRAMES;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam int PW   = $clog2(LED_W * ROUND_FRAMES + 1);
  localparam logic [TW-1:0] T_LAST  = TW'(ROUND_FRAMES - 1);
  localparam logic [CW-1:0] CD_LAST = CW'(COUNTDOWN_FRAMES - 1);
  localparam logic [CW-1:0] RS_LAST = CW'(RESULT_FRAMES - 1);
  localparam logic [7:0]    HALF    = 8'(NUM_ROUNDS / 2);
  localparam logic [7:0]    NR      = 8'(NUM_ROUNDS);

  typedef enum logic [2:0] {
    S_MENU = 3'd0, S_COUNTDOWN = 3'd1, S_PLAY = 3'd2,
    S_PAUSED = 3'd3, S_ROUND_END = 3'd4, S_MATCH_END = 3'd5
  } state_t;

  state_t             state;
  logic               cont_q, rst_q;
  logic [CW-1:0]      cnt;
  logic [TW-1:0]      timer;
  logic [SCORE_W-1:0] h1, h2, nh1, nh2;
  logic [7:0]         w1, w2, rnd;
  logic [1:0]         winner;
  logic               rstart, rend;
  logic               cont_edge, match_over;
  logic [PW-1:0]      prod, shamt;
  logic [LED_W-1:0]   led;

  // rst_q masks the first frame after reset. A Continue key held through
  // reset then needs a release and a re-press before it advances anything.
  assign cont_edge = bus.Continue & ~cont_q & ~rst_q;

  // Hits after this frame's point pulses; they saturate at all ones.
  always_comb begin
    nh1 = h1;
    nh2 = h2;
    if (bus.P1Point && h1 != '1) nh1 = h1 + 1'b1;
    if (bus.P2Point && h2 != '1) nh2 = h2 + 1'b1;
  end

  // The match ends when a majority is reached or the schedule runs out.
  always_comb begin
    match_over = (w1 > HALF) || (w2 > HALF) || (rnd >= NR);
`ifdef GAME_SUDDEN_DEATH_EN
    if (w1 == w2) match_over = 1'b0;
`else
`endif
  end

  // Time bar shrinks from the low end as the round timer advances.
  always_comb begin
    prod  = PW'(LED_W) * PW'(timer);
    shamt = prod / PW'(ROUND_FRAMES);
    led   = '1;
    case (state)
      S_PLAY, S_PAUSED:         led = {LED_W{1'b1}} << shamt;
      S_ROUND_END, S_MATCH_END: led = '0;
      default:                  led = '1;
    endcase
  end

  // Match FSM with registered counters, scores and pulses.
  always_ff @(posedge FrameClk or posedge Reset) begin
    if (Reset) begin
      state  <= S_MENU;
      cont_q <= 1'b0;
      rst_q  <= 1'b1;
      cnt    <= '0;
      timer  <= '0;
      h1     <= '0;
      h2     <= '0;
      w1     <= '0;
      w2     <= '0;
      rnd    <= '0;
      winner <= '0;
      rstart <= 1'b0;
      rend   <= 1'b0;
    end else begin
      cont_q <= bus.Continue;
      rst_q  <= 1'b0;
      rstart <= 1'b0;
      rend   <= 1'b0;
      case (state)
        S_MENU, S_MATCH_END: begin
          if (cont_edge) begin
            state  <= S_COUNTDOWN;
            cnt    <= '0;
            rnd    <= 8'd1;
            h1     <= '0;
            h2     <= '0;
            w1     <= '0;
            w2     <= '0;
            winner <= '0;
          end
        end
        S_COUNTDOWN: begin
          if (cnt == CD_LAST) begin
            state  <= S_PLAY;
            timer  <= '0;
            rstart <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_PLAY: begin
          // Expiry wins over Pause. The expiry frame's points still count.
          if (timer == T_LAST) begin
            state <= S_ROUND_END;
            cnt   <= '0;
            rend  <= 1'b1;
            h1    <= nh1;
            h2    <= nh2;
            if (nh1 > nh2)      w1 <= w1 + 8'd1;
            else if (nh2 > nh1) w2 <= w2 + 8'd1;
          end else if (bus.Pause) begin
            state <= S_PAUSED;
          end else begin
            timer <= timer + 1'b1;
            h1    <= nh1;
            h2    <= nh2;
          end
        end
        S_PAUSED: begin
          if (!bus.Pause) state <= S_PLAY;
        end
        S_ROUND_END: begin
          if (cnt == RS_LAST) begin
            if (match_over) begin
              state <= S_MATCH_END;
              if (w1 > w2)      winner <= 2'b01;
              else if (w2 > w1) winner <= 2'b10;
              else              winner <= 2'b11;
            end else begin
              state <= S_COUNTDOWN;
              cnt   <= '0;
              h1    <= '0;
              h2    <= '0;
              if (rnd != 8'hFF) rnd <= rnd + 8'd1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= S_MENU;
          rnd   <= '0;
        end
      endcase
    end
  end

  assign bus.State       = state;
  assign bus.SpawnEnable = (state == S_PLAY);
  assign bus.RoundNum    = rnd;
  assign bus.P1Hits      = h1;
  assign bus.P2Hits      = h2;
  assign bus.P1Wins      = w1;
  assign bus.P2Wins      = w2;
  assign bus.Winner      = winner;
  assign bus.RoundStart  = rstart;
  assign bus.RoundEnd    = rend;
  assign bus.LED         = led;
endmodule
